// File: rtl/dma_pkg.sv
// Shared parameters, state encoding and address helper for the memory-to-device DMA reader.
package dma_pkg;

    localparam int                   WORD_SIZE = 16;
    localparam logic [WORD_SIZE-1:0] BASE_ADDR = 16'h01F4;
    localparam int                   LENGTH    = 12;
    localparam int                   LINES     = LENGTH / 4;
    localparam int                   OFFSET_W  = 2;
    localparam logic [OFFSET_W-1:0]  LAST_OFFSET = OFFSET_W'(LINES - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ISSUE,
        SEND,
        DONE
    } state_e;

    // Each line is four words, so the line index is scaled by 4; wraps modulo 2^WORD_SIZE.
    function automatic logic [WORD_SIZE-1:0] line_addr(input logic [OFFSET_W-1:0] off);
        return BASE_ADDR + {{(WORD_SIZE - OFFSET_W - 2){1'b0}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/dma_reader_if.sv
// Bus, memory and device handshake signals of the DMA reader, seen from the engine (master) or its environment (slave).
interface dma_reader_if;
    import dma_pkg::*;

    logic                     cmd;
    logic                     BG;
    logic                     BR;
    logic                     READ;
    logic [4*WORD_SIZE-1:0]   mem_data;
    logic                     mem_ready;
    logic [4*WORD_SIZE-1:0]   dev_data;
    logic                     dev_valid;
    logic                     dev_ready;
    logic [OFFSET_W-1:0]      offset;
    logic                     interrupt;

    modport master (
        input  cmd, BG, mem_data, mem_ready, dev_ready,
        output BR, READ, dev_data, dev_valid, offset, interrupt
    );

    modport slave (
        output cmd, BG, mem_data, mem_ready, dev_ready,
        input  BR, READ, dev_data, dev_valid, offset, interrupt
    );

endinterface

// File: rtl/dma_line_buffer.sv
// One-line holding register between the memory read and the device handshake.
module dma_line_buffer
    import dma_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   clear,
    input  logic [4*WORD_SIZE-1:0] d,
    output logic [4*WORD_SIZE-1:0] q
);

    logic [4*WORD_SIZE-1:0] line_q, line_d;

    always_comb begin
        line_d = line_q;
        if (clear) begin
            line_d = '0;
        end else if (load) begin
            line_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign q = line_q;

endmodule

// File: rtl/dma_reader.sv
// Memory-to-device DMA engine: reads a fixed block line by line over the shared bus and forwards each line to a device.
module dma_reader
    import dma_pkg::*;
(
    input  logic                CLK,
    input  logic                reset_n,
    dma_reader_if.master        bus,
    output wire [WORD_SIZE-1:0] addr
);

    state_e              state_q, state_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic                br_q, br_d;
    logic                dev_valid_q, dev_valid_d;
    logic                interrupt_q, interrupt_d;
    logic                load, clear;
    logic                read, addr_en;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            offset_q    <= '0;
            br_q        <= 1'b0;
            dev_valid_q <= 1'b0;
            interrupt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            br_q        <= br_d;
            dev_valid_q <= dev_valid_d;
            interrupt_q <= interrupt_d;
        end
    end

    // Losing the grant freezes ISSUE, but the device handshake in SEND is independent of the bus.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        load     = 1'b0;
        clear    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd) begin
                    state_d = REQ;
                    clear   = 1'b1;
                end
            end
            REQ: begin
                if (bus.BG) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.BG && bus.mem_ready) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (dev_valid_q && bus.dev_ready) begin
                    if (offset_q == LAST_OFFSET) begin
                        offset_d = '0;
                        state_d  = DONE;
                    end else begin
                        offset_d = offset_q + 1'b1;
                        state_d  = ISSUE;
                    end
                end
            end
            DONE: begin
                if (!bus.BG) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs look at the next state so they change on the same edge as the state.
    always_comb begin
        br_d        = state_d inside {REQ, ISSUE, SEND};
        dev_valid_d = (state_d == SEND);
        interrupt_d = (state_d == DONE) && (state_q != DONE);
        read        = (state_q == ISSUE) && bus.BG;
        addr_en     = (state_q inside {ISSUE, SEND}) && bus.BG;
    end

    dma_line_buffer u_line_buffer (
        .clk   (CLK),
        .rst_n (reset_n),
        .load  (load),
        .clear (clear),
        .d     (bus.mem_data),
        .q     (bus.dev_data)
    );

    assign bus.BR        = br_q;
    assign bus.READ      = read;
    assign bus.dev_valid = dev_valid_q;
    assign bus.offset    = offset_q;
    assign bus.interrupt = interrupt_q;
    assign addr          = addr_en ? line_addr(offset_q) : 'z;

endmodule

// File: tb/tb_dma_reader.sv
// Directed bench for dma_reader: a per-cycle vector table for the basic block plus hand sequences for the corner cases.
module tb_dma_reader;
    import dma_pkg::*;

    localparam logic [63:0] D0   = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D1   = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [63:0] D2   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef struct {
        logic        cmd, bg, mr;
        logic [63:0] md;
        logic        dr;
        logic        br, rd;
        logic [15:0] addr;
        logic        dv;
        logic [63:0] dd;
        logic [1:0]  off;
        logic        irq;
    } vec_t;

    logic        CLK;
    logic        reset_n;
    wire  [15:0] addr;
    int          checks = 0;
    int          errors = 0;
    int          line_count = 0;
    int          irq_count = 0;
    vec_t        vecs[12];

    dma_reader_if bus();

    dma_reader dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .bus     (bus),
        .addr    (addr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Independent tally of accepted lines and interrupt pulses.
    always @(posedge CLK) begin
        if (bus.dev_valid && bus.dev_ready) line_count <= line_count + 1;
        if (bus.interrupt) irq_count <= irq_count + 1;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mk(logic cmd, logic bg, logic mr, logic [63:0] md, logic dr,
                                logic br, logic rd, logic [15:0] a, logic dv,
                                logic [63:0] dd, logic [1:0] off, logic irq);
        vec_t v;
        v.cmd = cmd; v.bg = bg; v.mr = mr; v.md = md; v.dr = dr;
        v.br = br; v.rd = rd; v.addr = a; v.dv = dv; v.dd = dd; v.off = off; v.irq = irq;
        return v;
    endfunction

    task automatic applyStimulus(input logic c, input logic g, input logic mr,
                                 input logic [63:0] md, input logic dr);
        bus.cmd       = c;
        bus.BG        = g;
        bus.mem_ready = mr;
        bus.mem_data  = md;
        bus.dev_ready = dr;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkState(input string tag, input logic br, input logic rd, input logic [15:0] a,
                              input logic dv, input logic [1:0] off, input logic irq);
        checkOutput($sformatf("%s.BR", tag), 64'(bus.BR), 64'(br));
        checkOutput($sformatf("%s.READ", tag), 64'(bus.READ), 64'(rd));
        if (rd) checkOutput($sformatf("%s.addr", tag), 64'(addr), 64'(a));
        checkOutput($sformatf("%s.dev_valid", tag), 64'(bus.dev_valid), 64'(dv));
        checkOutput($sformatf("%s.offset", tag), 64'(bus.offset), 64'(off));
        checkOutput($sformatf("%s.interrupt", tag), 64'(bus.interrupt), 64'(irq));
    endtask

    task automatic checkReset(input string tag);
        checkState(tag, 1'b0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
        checkOutput($sformatf("%s.dev_data", tag), bus.dev_data, 64'h0);
    endtask

    initial begin
        int lines_start, irq_start;

        bus.cmd = 1'b0; bus.BG = 1'b0; bus.mem_ready = 1'b0; bus.mem_data = '0; bus.dev_ready = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1 checkReset("reset");
        #10 reset_n = 1'b1;

        // Basic block: grant two cycles after BR, memory answers one cycle after READ, device always ready.
        vecs[0]  = mk(1, 0, 0, JUNK, 1,  1, 0, 16'h0000, 0, 64'h0, 2'd0, 0);
        vecs[1]  = mk(0, 0, 0, JUNK, 1,  1, 0, 16'h0000, 0, 64'h0, 2'd0, 0);
        vecs[2]  = mk(0, 1, 0, JUNK, 1,  1, 1, 16'h01F4, 0, 64'h0, 2'd0, 0);
        vecs[3]  = mk(0, 1, 1, D0,   1,  1, 0, 16'h0000, 1, D0,    2'd0, 0);
        vecs[4]  = mk(0, 1, 0, JUNK, 1,  1, 1, 16'h01F8, 0, D0,    2'd1, 0);
        vecs[5]  = mk(0, 1, 1, D1,   1,  1, 0, 16'h0000, 1, D1,    2'd1, 0);
        vecs[6]  = mk(0, 1, 0, JUNK, 1,  1, 1, 16'h01FC, 0, D1,    2'd2, 0);
        vecs[7]  = mk(0, 1, 1, D2,   1,  1, 0, 16'h0000, 1, D2,    2'd2, 0);
        vecs[8]  = mk(0, 1, 0, JUNK, 1,  0, 0, 16'h0000, 0, D2,    2'd0, 1);
        vecs[9]  = mk(0, 1, 0, JUNK, 1,  0, 0, 16'h0000, 0, D2,    2'd0, 0);
        vecs[10] = mk(0, 0, 0, JUNK, 1,  0, 0, 16'h0000, 0, D2,    2'd0, 0);
        vecs[11] = mk(0, 0, 0, JUNK, 1,  0, 0, 16'h0000, 0, D2,    2'd0, 0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].cmd, vecs[i].bg, vecs[i].mr, vecs[i].md, vecs[i].dr);
            checkState($sformatf("vec%0d", i), vecs[i].br, vecs[i].rd, vecs[i].addr,
                       vecs[i].dv, vecs[i].off, vecs[i].irq);
            checkOutput($sformatf("vec%0d.dev_data", i), bus.dev_data, vecs[i].dd);
        end

        // Backpressure on line 1, preemption during ISSUE of line 2, ignored cmd during SEND.
        lines_start = line_count;
        irq_start   = irq_count;
        applyStimulus(1, 0, 0, JUNK, 0);
        applyStimulus(0, 1, 0, JUNK, 0);
        applyStimulus(0, 1, 1, D0, 0);
        applyStimulus(0, 1, 0, JUNK, 1);
        checkState("bp_issue1", 1, 1, 16'h01F8, 0, 2'd1, 0);
        applyStimulus(0, 1, 1, D1, 0);
        checkOutput("bp_send1.dev_data", bus.dev_data, D1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, (i == 2) ? 1'b1 : 1'b0, JUNK, 0);
            checkState($sformatf("bp_hold%0d", i), 1, 0, 16'h0, 1, 2'd1, 0);
            checkOutput($sformatf("bp_hold%0d.dev_data", i), bus.dev_data, D1);
        end
        applyStimulus(0, 1, 0, JUNK, 1);
        checkState("pre_issue2", 1, 1, 16'h01FC, 0, 2'd2, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, (i == 1) ? 1'b1 : 1'b0, JUNK, 0);
            checkState($sformatf("pre_gap%0d", i), 1, 0, 16'h0, 0, 2'd2, 0);
            checks++;
            if (addr === 16'h01FC) begin
                errors++;
                $display("[TB] FAIL pre_gap%0d.addr_released: got %h expected high-Z", i, addr);
            end
        end
        applyStimulus(0, 1, 0, JUNK, 0);
        checkState("pre_regrant", 1, 1, 16'h01FC, 0, 2'd2, 0);
        applyStimulus(0, 1, 1, D2, 0);
        checkState("pre_send2", 1, 0, 16'h0, 1, 2'd2, 0);
        checkOutput("pre_send2.dev_data", bus.dev_data, D2);
        applyStimulus(1, 1, 0, JUNK, 0);
        checkState("cmd_in_send", 1, 0, 16'h0, 1, 2'd2, 0);
        applyStimulus(0, 1, 0, JUNK, 1);
        checkState("ign_done", 0, 0, 16'h0, 0, 2'd0, 1);
        applyStimulus(0, 0, 0, JUNK, 0);
        applyStimulus(0, 0, 0, JUNK, 0);
        applyStimulus(0, 0, 0, JUNK, 0);
        checkState("ign_idle", 0, 0, 16'h0, 0, 2'd0, 0);
        checkOutput("ign_lines", 64'(line_count - lines_start), 64'd3);
        checkOutput("ign_irqs", 64'(irq_count - irq_start), 64'd1);

        // Back-to-back blocks: best-case block, grant dropped one cycle after the interrupt, then a new cmd.
        applyStimulus(1, 0, 0, JUNK, 1);
        applyStimulus(0, 1, 0, JUNK, 1);
        applyStimulus(0, 1, 1, D0, 1);
        applyStimulus(0, 1, 0, JUNK, 1);
        applyStimulus(0, 1, 1, D1, 1);
        applyStimulus(0, 1, 0, JUNK, 1);
        applyStimulus(0, 1, 1, D2, 1);
        applyStimulus(0, 1, 0, JUNK, 1);
        checkState("b2b_done", 0, 0, 16'h0, 0, 2'd0, 1);
        applyStimulus(0, 0, 0, JUNK, 1);
        checkState("b2b_idle", 0, 0, 16'h0, 0, 2'd0, 0);
        applyStimulus(1, 0, 0, JUNK, 1);
        checkState("b2b_req", 1, 0, 16'h0, 0, 2'd0, 0);
        applyStimulus(0, 1, 0, JUNK, 0);
        checkState("b2b_issue0", 1, 1, 16'h01F4, 0, 2'd0, 0);

        // Reset during SEND of line 1, then restart from the first line.
        applyStimulus(0, 1, 1, D0, 0);
        applyStimulus(0, 1, 0, JUNK, 1);
        applyStimulus(0, 1, 1, D1, 0);
        checkState("rst_send1", 1, 0, 16'h0, 1, 2'd1, 0);
        #2 reset_n = 1'b0;
        #1 checkReset("rst_async");
        @(posedge CLK);
        #1 checkReset("rst_held");
        #2 reset_n = 1'b1;
        applyStimulus(1, 1, 0, JUNK, 0);
        checkState("rst_req", 1, 0, 16'h0, 0, 2'd0, 0);
        applyStimulus(0, 1, 0, JUNK, 0);
        checkState("rst_restart", 1, 1, 16'h01F4, 0, 2'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
